// File: rtl/reg_scoreboard.sv
// Register scoreboard and issue controller for the Read stage: counts in-flight writers
// per GPR, grants issue only when every source is clean, and drains after a flush.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issueValidIn,
  input  logic [3:0]          src1In,
  input  logic [3:0]          src2In,
  input  logic                src1ValidIn,
  input  logic                src2ValidIn,
  input  logic                readsRspIn,
  input  logic [3:0]          destIn,
  input  logic                destValidIn,
  input  logic [3:0]          destSpecialIn,
  input  logic                destSpecialValidIn,
  input  logic                downstreamStallIn,
  input  logic                wbValidIn,
  input  logic [3:0]          wbDestIn,
  input  logic                wbDestValidIn,
  input  logic [3:0]          wbSpecialIn,
  input  logic                wbSpecialValidIn,
  input  logic                flushIn,
  output logic                issueAcceptOut,
  output logic                stallOut,
  output logic [NUM_REGS-1:0] busyMaskOut,
  output logic                drainingOut,
  output logic                errorOut
);

  localparam int              SUM_W    = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);
  localparam int              RSP_CODE = 4;
  localparam logic [0:0]      ST_RUN   = 1'b0;
  localparam logic [0:0]      ST_DRAIN = 1'b1;

  logic [CNT_W-1:0]    count_q [NUM_REGS];
  logic [CNT_W-1:0]    count_d [NUM_REGS];
  logic [0:0]          state_q, state_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] sat_vec;
  logic [NUM_REGS-1:0] under_vec;
  logic [NUM_REGS-1:0] busy;
  logic                hazard;

  // Number of the two (valid, code) pairs that name register r: 0..2.
  function automatic logic [1:0] hits(input logic v0, input logic [3:0] c0,
                                      input logic v1, input logic [3:0] c1,
                                      input logic [3:0] r);
    return {1'b0, v0 && (c0 == r)} + {1'b0, v1 && (c1 == r)};
  endfunction

  function automatic logic would_sat(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    return (inc != 2'd0) && ((SUM_W'(cnt) + SUM_W'(inc)) > CNT_MAX);
  endfunction

  // Returns {underflow, next count}; an over-retire clamps the count at zero.
  function automatic logic [CNT_W:0] next_count(input logic [CNT_W-1:0] cnt,
                                                input logic [1:0] inc,
                                                input logic [1:0] dec);
    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] diff;
    up   = SUM_W'(cnt) + SUM_W'(inc);
    diff = up - SUM_W'(dec);
    if (SUM_W'(dec) > up) return {1'b1, {CNT_W{1'b0}}};
    return {1'b0, diff[CNT_W-1:0]};
  endfunction

  // Hazard looks at registered counts only, so a retiring writer frees its reg next cycle.
  assign hazard = (src1ValidIn && (count_q[src1In] != '0)) ||
                  (src2ValidIn && (count_q[src2In] != '0)) ||
                  (readsRspIn  && (count_q[RSP_CODE] != '0));

  assign issueAcceptOut = issueValidIn && (state_q == ST_RUN) && !hazard && !(|sat_vec) &&
                          !downstreamStallIn && !flushIn;
  assign stallOut       = issueValidIn && !issueAcceptOut;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    localparam logic [3:0] CODE = 4'(r);
    logic [1:0] inc_pot;
    logic [1:0] inc;
    logic [1:0] dec;

    assign inc_pot = hits(destValidIn, destIn, destSpecialValidIn, destSpecialIn, CODE);
    assign inc     = issueAcceptOut ? inc_pot : 2'd0;
    assign dec     = wbValidIn ? hits(wbDestValidIn, wbDestIn, wbSpecialValidIn, wbSpecialIn, CODE)
                               : 2'd0;
    assign sat_vec[r] = would_sat(count_q[r], inc_pot);
    assign {under_vec[r], count_d[r]} = next_count(count_q[r], inc, dec);
    assign busy[r] = (count_q[r] != '0);
  end

  assign err_d = err_q || (|under_vec);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flushIn) state_d = ST_DRAIN;
      ST_DRAIN: if (!flushIn && !(|busy)) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= count_d[r];
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign busyMaskOut = busy;
  assign drainingOut = (state_q == ST_DRAIN);
  assign errorOut    = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a driver pushes model expectations into a queue,
// a negedge monitor pops and compares; directed scenarios plus randomized traffic.
module tb_reg_scoreboard;
  localparam int NR   = 16;
  localparam int CW   = 2;
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issueValidIn, src1ValidIn, src2ValidIn, readsRspIn, destValidIn, destSpecialValidIn;
  logic downstreamStallIn, wbValidIn, wbDestValidIn, wbSpecialValidIn, flushIn;
  logic [3:0] src1In, src2In, destIn, destSpecialIn, wbDestIn, wbSpecialIn;
  logic issueAcceptOut, stallOut, drainingOut, errorOut;
  logic [NR-1:0] busyMaskOut;

  reg_scoreboard #(.NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .issueValidIn(issueValidIn), .src1In(src1In), .src2In(src2In),
    .src1ValidIn(src1ValidIn), .src2ValidIn(src2ValidIn), .readsRspIn(readsRspIn),
    .destIn(destIn), .destValidIn(destValidIn),
    .destSpecialIn(destSpecialIn), .destSpecialValidIn(destSpecialValidIn),
    .downstreamStallIn(downstreamStallIn),
    .wbValidIn(wbValidIn), .wbDestIn(wbDestIn), .wbDestValidIn(wbDestValidIn),
    .wbSpecialIn(wbSpecialIn), .wbSpecialValidIn(wbSpecialValidIn),
    .flushIn(flushIn),
    .issueAcceptOut(issueAcceptOut), .stallOut(stallOut), .busyMaskOut(busyMaskOut),
    .drainingOut(drainingOut), .errorOut(errorOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] s1, s2;
    logic       s1v, s2v, rsp;
    logic [3:0] d, ds;
    logic       dv, dsv, stl;
    logic       wv;
    logic [3:0] wd, ws;
    logic       wdv, wsv, fl;
  } in_t;

  typedef struct {
    logic          acc, stall, drn, err;
    logic [NR-1:0] busy;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int   m_cnt[NR];
  bit   m_drain, m_err;
  bit   rst_drv = 1'b1;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic in_t idle();
    in_t x;
    x = '{default: '0};
    return x;
  endfunction

  function automatic int nhit(input logic v0, input logic [3:0] c0,
                              input logic v1, input logic [3:0] c1, input int r);
    return ((v0 && int'(c0) == r) ? 1 : 0) + ((v1 && int'(c1) == r) ? 1 : 0);
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    m_drain = 1'b0;
    m_err   = 1'b0;
  endfunction

  // One clock: drive inputs, push the expected outputs, then advance the model.
  task automatic cycle(input in_t x);
    exp_t e;
    bit hz, sat, acc, allz;
    int n;
    @(posedge clk); #1;
    reset = rst_drv;
    issueValidIn = x.iv; src1In = x.s1; src2In = x.s2; src1ValidIn = x.s1v; src2ValidIn = x.s2v;
    readsRspIn = x.rsp; destIn = x.d; destValidIn = x.dv; destSpecialIn = x.ds;
    destSpecialValidIn = x.dsv; downstreamStallIn = x.stl; wbValidIn = x.wv; wbDestIn = x.wd;
    wbDestValidIn = x.wdv; wbSpecialIn = x.ws; wbSpecialValidIn = x.wsv; flushIn = x.fl;
    if (rst_drv) model_reset();
    hz = (x.s1v && m_cnt[x.s1] > 0) || (x.s2v && m_cnt[x.s2] > 0) || (x.rsp && m_cnt[4] > 0);
    sat = 1'b0;
    for (int r = 0; r < NR; r++) begin
      n = nhit(x.dv, x.d, x.dsv, x.ds, r);
      if (n > 0 && m_cnt[r] + n > MAXC) sat = 1'b1;
    end
    acc = x.iv && !m_drain && !hz && !sat && !x.stl && !x.fl && !rst_drv;
    e.acc = acc;
    e.stall = x.iv && !acc;
    e.drn = m_drain;
    e.err = m_err;
    allz = 1'b1;
    for (int r = 0; r < NR; r++) begin
      e.busy[r] = (m_cnt[r] > 0);
      if (m_cnt[r] > 0) allz = 1'b0;
    end
    expq.push_back(e);
    if (rst_drv) return;
    for (int r = 0; r < NR; r++) begin
      n = m_cnt[r] + (acc ? nhit(x.dv, x.d, x.dsv, x.ds, r) : 0)
          - (x.wv ? nhit(x.wdv, x.wd, x.wsv, x.ws, r) : 0);
      if (n < 0) begin
        n = 0;
        m_err = 1'b1;
      end
      m_cnt[r] = n;
    end
    if (!m_drain) m_drain = x.fl;
    else if (!x.fl && allz) m_drain = 1'b0;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      me = expq.pop_front();
      chk("accept", 16'(issueAcceptOut), 16'(me.acc));
      chk("stall", 16'(stallOut), 16'(me.stall));
      chk("busy_mask", busyMaskOut, me.busy);
      chk("draining", 16'(drainingOut), 16'(me.drn));
      chk("error", 16'(errorOut), 16'(me.err));
    end
  end

  task automatic retire_all();
    in_t x;
    for (int k = 0; k < 64; k++) begin
      x = idle();
      for (int r = NR - 1; r >= 0; r--)
        if (m_cnt[r] > 0) begin
          x.wv = 1'b1; x.wdv = 1'b1; x.wd = 4'(r);
        end
      if (!x.wv && !m_drain) break;
      cycle(x);
    end
  endtask

  function automatic in_t issue(input int d);
    in_t x;
    x = idle();
    x.iv = 1'b1; x.dv = 1'b1; x.d = 4'(d);
    return x;
  endfunction

  initial begin
    in_t x;
    int bl[$];
    int r1, r2;
    cycle(idle());
    #1 chk("reset_busy", busyMaskOut, 16'h0000);
    cycle(idle());
    rst_drv = 1'b0;
    cycle(idle());

    // RAW: reader of r3 waits until the writer retires, then one more cycle
    cycle(issue(3));
    x = idle(); x.iv = 1'b1; x.s1v = 1'b1; x.s1 = 4'd3;
    cycle(x);
    #1 chk("raw_stall", 16'(stallOut), 16'h0001);
    cycle(x);
    x.wv = 1'b1; x.wdv = 1'b1; x.wd = 4'd3;
    cycle(x);
    #1 chk("raw_no_bypass", 16'(issueAcceptOut), 16'h0000);
    x.wv = 1'b0; x.wdv = 1'b0;
    cycle(x);
    #1 chk("raw_accept", 16'(issueAcceptOut), 16'h0001);
    retire_all();

    // Same-cycle issue and writeback to r5
    cycle(issue(5));
    x = issue(5); x.wv = 1'b1; x.wdv = 1'b1; x.wd = 4'd5;
    cycle(x);
    cycle(idle());
    #1 chk("same_cycle_busy", busyMaskOut, 16'h0020);
    retire_all();

    // Saturation on r2
    for (int k = 0; k < 3; k++) cycle(issue(2));
    cycle(issue(2));
    #1 chk("sat_stall", 16'(stallOut), 16'h0001);
    x = issue(2); x.wv = 1'b1; x.wdv = 1'b1; x.wd = 4'd2;
    cycle(x);
    cycle(issue(2));
    #1 chk("sat_accept", 16'(issueAcceptOut), 16'h0001);
    retire_all();

    // IMUL two destinations, then RETQ against a pending RSP writer
    x = issue(0); x.dsv = 1'b1; x.ds = 4'd2;
    cycle(x);
    cycle(idle());
    #1 chk("imul_busy", busyMaskOut, 16'h0005);
    cycle(issue(4));
    x = idle(); x.iv = 1'b1; x.rsp = 1'b1;
    cycle(x);
    #1 chk("retq_stall", 16'(stallOut), 16'h0001);
    retire_all();

    // Flush with two writers in flight
    cycle(issue(1));
    cycle(issue(6));
    x = issue(9); x.fl = 1'b1;
    cycle(x);
    cycle(issue(9));
    #1 chk("flush_draining", 16'(drainingOut), 16'h0001);
    x = issue(9); x.wv = 1'b1; x.wdv = 1'b1; x.wd = 4'd1;
    cycle(x);
    x.wd = 4'd6;
    cycle(x);
    cycle(issue(9));
    cycle(issue(9));
    #1 chk("flush_resume", 16'(issueAcceptOut), 16'h0001);
    retire_all();

    // Flush with nothing pending still drains for one cycle
    x = idle(); x.fl = 1'b1;
    cycle(x);
    cycle(issue(8));
    cycle(issue(8));
    retire_all();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      x = idle();
      x.iv  = ($urandom_range(0, 3) != 0);
      x.s1  = 4'($urandom_range(0, 7));  x.s1v = ($urandom_range(0, 1) != 0);
      x.s2  = 4'($urandom_range(0, 7));  x.s2v = ($urandom_range(0, 1) != 0);
      x.rsp = ($urandom_range(0, 7) == 0);
      x.d   = 4'($urandom_range(0, 7));  x.dv  = ($urandom_range(0, 3) != 0);
      x.ds  = 4'($urandom_range(0, 7));  x.dsv = ($urandom_range(0, 5) == 0);
      x.stl = ($urandom_range(0, 7) == 0);
      x.fl  = ($urandom_range(0, 31) == 0);
      bl.delete();
      for (int r = 0; r < NR; r++) if (m_cnt[r] > 0) bl.push_back(r);
      if (bl.size() > 0 && $urandom_range(0, 2) != 0) begin
        r1 = bl[$urandom_range(0, bl.size() - 1)];
        r2 = bl[$urandom_range(0, bl.size() - 1)];
        x.wv = 1'b1; x.wdv = ($urandom_range(0, 5) != 0); x.wd = 4'(r1);
        x.ws = 4'(r2);
        x.wsv = ($urandom_range(0, 3) == 0) && (!x.wdv || r2 != r1 || m_cnt[r1] >= 2);
      end else begin
        x.wdv = ($urandom_range(0, 1) != 0); x.wd = 4'($urandom_range(0, 15));
      end
      cycle(x);
    end
    retire_all();

    // Underflow is sticky
    x = idle(); x.wv = 1'b1; x.wdv = 1'b1; x.wd = 4'd7;
    cycle(x);
    for (int k = 0; k < 3; k++) cycle(issue(k));
    #1 chk("err_sticky", 16'(errorOut), 16'h0001);

    // Asynchronous reset mid-run
    @(posedge clk); #3;
    reset = 1'b1;
    #1 chk("async_rst_busy", busyMaskOut, 16'h0000);
    chk("async_rst_err", 16'(errorOut), 16'h0000);
    chk("async_rst_drn", 16'(drainingOut), 16'h0000);
    rst_drv = 1'b1;
    cycle(idle());
    rst_drv = 1'b0;
    cycle(idle());
    cycle(issue(3));
    cycle(issue(3));
    retire_all();

    @(posedge clk);
    @(negedge clk); #1;
    chk("queue_drained", 16'(expq.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
